led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
Multiplexed 8-digit seven-segment scan controller that sequences the 74HC595 serial driver (hc595_driver) on the display board. It captures a 32-bit hex display value, decodes one digit at a time and presents {sel, seg} words on the driver's 16-bit data input. It changes a word only on driver frame boundaries and inserts blanking frames between digits to suppress ghosting. The top level instantiates this block beside hc595_driver; hc_en and hc_data connect directly to the driver's en and data inputs.

Parameters:
DIGITS, 8, number of scanned digits (1..8); sel bits above DIGITS-1 are always 0
FRAME_CYCLES, 128, clk_50mhz cycles per driver shift/latch frame (32 ticks of 12.5 MHz)
DWELL_FRAMES, 390, frames each digit is shown (~1 ms)
BLANK_FRAMES, 1, all-off frames inserted after each digit (0 = no blanking)

Ports:
clk_50mhz  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable, level
disp_data  in  32  eight hex nibbles; nibble n (bits 4n+3:4n) drives digit n
dp_mask  in  8  decimal point per digit, 1 = lit
digit_en  in  8  per-digit enable, 0 = digit dark
hc_en  out  1  enable to hc595_driver
hc_data  out  16  {sel[7:0], seg[7:0]} to hc595_driver
scan_start  out  1  one-cycle pulse when a new scan (digit 0) begins

Behaviour:
- Reset is asynchronous and active-low on rst_n; the clock is clk_50mhz.
- Reset values: state IDLE, hc_en=0, hc_data=16'h00FF, scan_start=0, digit index 0, phase 0, frame count 0, captured value 0.
- Word format: sel is one-hot and active-high (bit n = digit n). seg is active-low, common anode: bit7=dp, bits6..0 = g..a. The all-off word is 16'h00FF.
- Hex decode for 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. Bit7 is cleared when dp_mask[n]=1.
- States: IDLE, SHOW, BLANK. All outputs are registered.
- IDLE:
  - On enable=1, next cycle: capture disp_data, dp_mask and digit_en; digit=0; phase=0; state SHOW; hc_en=1; hc_data = word for digit 0; scan_start=1.
- Phase counter:
  - Counts 0..FRAME_CYCLES-1 and wraps while in SHOW or BLANK.
  - A frame ends at phase = FRAME_CYCLES-1.
  - hc_data may change only in the cycle after a frame end. It is stable for whole 128-cycle frames.
- SHOW:
  - After DWELL_FRAMES frame ends, go to BLANK if BLANK_FRAMES>0; otherwise go directly to the next digit.
  - A digit with digit_en=0 still consumes its SHOW frames, but its word is 16'h00FF. Scan timing is therefore uniform.
- BLANK: hc_data=16'h00FF. After BLANK_FRAMES frame ends, advance the digit.
- Digit advance:
  - From DIGITS-1 the digit wraps to 0.
  - On wrap, disp_data, dp_mask and digit_en are re-captured and scan_start pulses for one cycle, coincident with the digit-0 word update.
  - Input changes mid-scan are not visible until the next wrap.
- enable=0 in any state: next cycle, state IDLE, hc_en=0, hc_data=16'h00FF, counters cleared. This takes priority over a simultaneous frame end.
- Re-enable always restarts at digit 0 with a fresh capture.
- Latency: enable rise to first hc_en=1 is 1 cycle. One full scan is DIGITS*(DWELL_FRAMES+BLANK_FRAMES)*FRAME_CYCLES cycles.
- Counter widths: frame count sized by $clog2 of max(DWELL_FRAMES, BLANK_FRAMES)+1; phase sized by $clog2(FRAME_CYCLES). Neither counter may overflow.

Decomposition:
- Shared package led_display_pkg holds:
  - the state enum (IDLE/SHOW/BLANK);
  - SEG_OFF=8'hFF and WORD_OFF=16'h00FF;
  - the 16-entry hex-to-segment constant table.
- Sub-module hex_to_seg7: combinational nibble+dp to seg[7:0] decode, reused by other display blocks.

Test Plan:
Bench parameters: FRAME_CYCLES=128, DWELL_FRAMES=2, BLANK_FRAMES=1.
1. Reset held, then released with enable=0 -> hc_en=0 and hc_data=16'h00FF indefinitely; scan_start never pulses.
2. disp_data=32'h76543210, dp_mask=0, digit_en=8'hFF, enable=1 ->
   - next cycle: hc_en=1, scan_start=1, hc_data=16'h01C0 held 256 cycles;
   - then 16'h00FF for 128 cycles;
   - then 16'h02F9 held 256 cycles;
   - hc_data never changes except at 128-cycle boundaries.
3. After digit 7 (16'h80F8), change disp_data to 32'h0000000F mid-scan -> at wrap scan_start pulses and hc_data=16'h018E. The new value never appears before the wrap.
4. digit_en=8'hFE, dp_mask=8'h02 with 32'h76543210 -> digit 0 frames are 16'h00FF; digit 1 is 16'h0279. Timing is identical to scenario 2.
5. enable dropped mid-SHOW of digit 3, coincident with a frame end -> next cycle hc_en=0 and hc_data=16'h00FF. Re-assert -> restart at 16'h01C0 with a scan_start pulse.
6. rst_n asserted mid-BLANK -> outputs take reset values immediately (asynchronously, before the next clock edge). After release with enable=1, the scan restarts at digit 0.

Source files
------------

// File: rtl/led_display_pkg.sv
// Shared definitions for seven-segment display blocks: scan states, off words
// and the common-anode hex segment table.
package led_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_e;

  localparam logic [7:0]  SEG_OFF  = 8'hFF;
  localparam logic [15:0] WORD_OFF = 16'h00FF;

  // Active-low segments, bit7 = dp, bits6..0 = g..a; dp is off in every entry.
  localparam logic [7:0] HEX_SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to common-anode seven-segment decode with decimal point.
module hex_to_seg7
  import led_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    seg_o = HEX_SEG_TABLE[nibble_i];
    if (dp_i) seg_o[7] = 1'b0;
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed seven-segment scan controller feeding {sel, seg} words to the
// hc595 serial driver, changing words only on driver frame boundaries.
module led_scan_ctrl
  import led_display_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int FRAME_CYCLES = 128,
  parameter int DWELL_FRAMES = 390,
  parameter int BLANK_FRAMES = 1
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  output logic        hc_en,
  output logic [15:0] hc_data,
  output logic        scan_start
);

  localparam int PHASE_W   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int FRAME_MAX = (DWELL_FRAMES > BLANK_FRAMES) ? DWELL_FRAMES : BLANK_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int DIGIT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FRAME_CYCLES - 1);
  localparam logic [FRAME_W-1:0] DWELL_LAST = FRAME_W'(DWELL_FRAMES - 1);
  localparam logic [FRAME_W-1:0] BLANK_LAST = FRAME_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);

  scan_state_e        state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         dp_q, dp_d;
  logic [7:0]         den_q, den_d;
  logic               hc_en_q, hc_en_d;
  logic [15:0]        hc_data_q, hc_data_d;
  logic               scan_start_q, scan_start_d;

  // Word for the digit about to be shown; a fresh capture applies on scan start.
  logic               wrap, fresh, frame_end, advance;
  logic [DIGIT_W-1:0] digit_inc, tgt_digit;
  logic [31:0]        src_data;
  logic [7:0]         src_dp, src_den, tgt_sel, tgt_seg;
  logic [3:0]         tgt_nibble;
  logic [15:0]        tgt_word;

  always_comb begin
    wrap       = (digit_q == DIGIT_LAST);
    digit_inc  = wrap ? '0 : digit_q + 1'b1;
    fresh      = (state_q == IDLE) || wrap;
    tgt_digit  = (state_q == IDLE) ? '0 : digit_inc;
    src_data   = fresh ? disp_data : data_q;
    src_dp     = fresh ? dp_mask   : dp_q;
    src_den    = fresh ? digit_en  : den_q;
    tgt_nibble = src_data[{tgt_digit, 2'b00} +: 4];
    tgt_sel    = 8'h01 << tgt_digit;
    tgt_word   = src_den[tgt_digit] ? {tgt_sel, tgt_seg} : {8'h00, SEG_OFF};
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (tgt_nibble),
    .dp_i     (src_dp[tgt_digit]),
    .seg_o    (tgt_seg)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    frame_d      = frame_q;
    digit_d      = digit_q;
    data_d       = data_q;
    dp_d         = dp_q;
    den_d        = den_q;
    hc_en_d      = hc_en_q;
    hc_data_d    = hc_data_q;
    scan_start_d = 1'b0;
    frame_end    = (phase_q == PHASE_LAST);
    advance      = 1'b0;

    if (!enable) begin
      state_d   = IDLE;
      hc_en_d   = 1'b0;
      hc_data_d = WORD_OFF;
      phase_d   = '0;
      frame_d   = '0;
      digit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: advance = 1'b1;
        SHOW, BLANK: begin
          phase_d = frame_end ? '0 : phase_q + 1'b1;
          if (frame_end) begin
            if (state_q == SHOW && frame_q == DWELL_LAST) begin
              frame_d = '0;
              if (BLANK_FRAMES > 0) begin
                state_d   = BLANK;
                hc_data_d = WORD_OFF;
              end else begin
                advance = 1'b1;
              end
            end else if (state_q == BLANK && frame_q == BLANK_LAST) begin
              frame_d = '0;
              advance = 1'b1;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        state_d      = SHOW;
        hc_en_d      = 1'b1;
        digit_d      = tgt_digit;
        hc_data_d    = tgt_word;
        scan_start_d = fresh;
        if (fresh) begin
          data_d = disp_data;
          dp_d   = dp_mask;
          den_d  = digit_en;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      frame_q      <= '0;
      digit_q      <= '0;
      data_q       <= '0;
      dp_q         <= '0;
      den_q        <= '0;
      hc_en_q      <= 1'b0;
      hc_data_q    <= WORD_OFF;
      scan_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      frame_q      <= frame_d;
      digit_q      <= digit_d;
      data_q       <= data_d;
      dp_q         <= dp_d;
      den_q        <= den_d;
      hc_en_q      <= hc_en_d;
      hc_data_q    <= hc_data_d;
      scan_start_q <= scan_start_d;
    end
  end

  assign hc_en      = hc_en_q;
  assign hc_data    = hc_data_q;
  assign scan_start = scan_start_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: expected per-cycle outputs are queued as
// stimulus is applied and compared on every falling clock edge.
module tb_led_scan_ctrl;

  localparam int FRAME = 128;
  localparam int DWELL = 2;
  localparam int BLANK = 1;
  localparam int DIGIT_CYC = (DWELL + BLANK) * FRAME;
  localparam int SCAN_CYC  = 8 * DIGIT_CYC;

  typedef struct packed {
    logic        en;
    logic [15:0] data;
    logic        ss;
  } exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  den;
  } in_t;

  logic        clk_50mhz = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] disp_data;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic        hc_en;
  logic [15:0] hc_data;
  logic        scan_start;

  exp_t  exp_q [$];
  exp_t  cur_e;
  string tag;
  int    n_cmp = 0;
  int    n_err = 0;

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  always #10 clk_50mhz = ~clk_50mhz;

  led_scan_ctrl #(
    .DIGITS       (8),
    .FRAME_CYCLES (FRAME),
    .DWELL_FRAMES (DWELL),
    .BLANK_FRAMES (BLANK)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
    .enable     (enable),
    .disp_data  (disp_data),
    .dp_mask    (dp_mask),
    .digit_en   (digit_en),
    .hc_en      (hc_en),
    .hc_data    (hc_data),
    .scan_start (scan_start)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input in_t c, input int d);
    logic [7:0] seg;
    logic [7:0] sel;
    if (!c.den[d]) return 16'h00FF;
    seg = seg_tab[c.data[4*d +: 4]];
    if (c.dp[d]) seg[7] = 1'b0;
    sel = 8'h01 << d;
    return {sel, seg};
  endfunction

  // Expected outputs at cycle k of a scan that started from capture c.
  function automatic exp_t exp_at(input in_t c, input int k);
    exp_t e;
    int   r;
    r      = k % DIGIT_CYC;
    e.en   = 1'b1;
    e.data = (r < DWELL * FRAME) ? exp_word(c, k / DIGIT_CYC) : 16'h00FF;
    e.ss   = (k == 0);
    return e;
  endfunction

  always @(negedge clk_50mhz) begin
    if (exp_q.size() != 0) begin
      cur_e = exp_q.pop_front();
      check({tag, "/hc_en"},      32'(hc_en),      32'(cur_e.en));
      check({tag, "/hc_data"},    32'(hc_data),    32'(cur_e.data));
      check({tag, "/scan_start"}, 32'(scan_start), 32'(cur_e.ss));
    end
  end

  // Advance n falling edges, ending just after the last one so inputs change between samples.
  task automatic run(input int n);
    repeat (n) @(negedge clk_50mhz);
    #1;
  endtask

  task automatic expect_off(input int n);
    exp_t e;
    e = '{en: 1'b0, data: 16'h00FF, ss: 1'b0};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    run(n);
  endtask

  task automatic expect_scan(input in_t c, input int k0, input int k1);
    for (int k = k0; k < k1; k++) exp_q.push_back(exp_at(c, k));
    run(k1 - k0);
  endtask

  in_t cap_a, cap_b, cap_c;

  initial begin
    cap_a = '{data: 32'h76543210, dp: 8'h00, den: 8'hFF};
    cap_b = '{data: 32'h0000000F, dp: 8'h00, den: 8'hFF};
    cap_c = '{data: 32'h76543210, dp: 8'h02, den: 8'hFE};

    rst_n     = 1'b0;
    enable    = 1'b0;
    disp_data = 32'h0;
    dp_mask   = 8'h0;
    digit_en  = 8'h0;
    @(negedge clk_50mhz);
    #1;

    tag = "reset";
    expect_off(3);
    rst_n = 1'b1;
    tag = "idle";
    expect_off(20);

    tag = "scan_a";
    disp_data = cap_a.data;
    dp_mask   = cap_a.dp;
    digit_en  = cap_a.den;
    enable    = 1'b1;
    expect_scan(cap_a, 0, 3 * DIGIT_CYC + 100);

    tag = "midscan_change";
    disp_data = cap_b.data;
    expect_scan(cap_a, 3 * DIGIT_CYC + 100, SCAN_CYC);

    tag = "scan_b";
    expect_scan(cap_b, 0, 1000);
    disp_data = cap_c.data;
    dp_mask   = cap_c.dp;
    digit_en  = cap_c.den;
    expect_scan(cap_b, 1000, SCAN_CYC);

    tag = "scan_c";
    expect_scan(cap_c, 0, 3 * DIGIT_CYC + FRAME);

    tag = "disable";
    enable   = 1'b0;
    dp_mask  = cap_a.dp;
    digit_en = cap_a.den;
    expect_off(6);

    tag = "reenable";
    enable = 1'b1;
    expect_scan(cap_a, 0, DIGIT_CYC + 50);
    expect_scan(cap_a, DIGIT_CYC + 50, DIGIT_CYC + DWELL * FRAME + 60);

    tag = "async_reset";
    rst_n = 1'b0;
    #1;
    check("async_reset/hc_en",      32'(hc_en),      32'h0);
    check("async_reset/hc_data",    32'(hc_data),    32'h00FF);
    check("async_reset/scan_start", 32'(scan_start), 32'h0);
    expect_off(3);

    tag = "restart";
    rst_n = 1'b1;
    expect_scan(cap_a, 0, 400);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
